// File: rtl/vga_cursor_pipe_pkg.sv
// Shared encodings for the VGA cursor overlay path.
package vga_cursor_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_SOLID   = 2'b01,
        MODE_OUTLINE = 2'b10,
        MODE_INVERT  = 2'b11
    } mode_e;

    localparam int VGA_CNT_W = 12;

endpackage

// File: rtl/vga_cursor_pipe_if.sv
// Pixel/timing bundle into and out of the cursor overlay stage, plus the cursor controls.
interface vga_cursor_pipe_if #(
    parameter int CNT_W = 12,
    parameter int RGB_W = 12
);
    logic             vs_in;
    logic             hs_in;
    logic             blank_in;
    logic [CNT_W-1:0] hcount_in;
    logic [CNT_W-1:0] vcount_in;
    logic [RGB_W-1:0] rgb_in;
    logic [CNT_W-1:0] xpos;
    logic [CNT_W-1:0] ypos;
    logic [1:0]       mode;

    logic             vs_out;
    logic             hs_out;
    logic             blank_out;
    logic [CNT_W-1:0] hcount_out;
    logic [CNT_W-1:0] vcount_out;
    logic [RGB_W-1:0] rgb_out;

    modport master (
        output vs_in, hs_in, blank_in, hcount_in, vcount_in, rgb_in, xpos, ypos, mode,
        input  vs_out, hs_out, blank_out, hcount_out, vcount_out, rgb_out
    );

    modport slave (
        input  vs_in, hs_in, blank_in, hcount_in, vcount_in, rgb_in, xpos, ypos, mode,
        output vs_out, hs_out, blank_out, hcount_out, vcount_out, rgb_out
    );
endinterface

// File: rtl/vga_cursor_pipe_delay_line.sv
// Generic sync-reset shift register, DEPTH cycles of delay (DEPTH=0 is a wire).
// No backpressure: shifts every clock.
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctl;
            assign unused_ctl = clk ^ rst;
            assign q_o = d_i;
        end else begin : g_shift
            logic [WIDTH-1:0] sr_q [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
                end else begin
                    sr_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
                end
            end

            assign q_o = sr_q[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/vga_cursor_pipe.sv
// Cursor overlay + timing alignment; every output is its input delayed exactly LAT pclk cycles.
// One pixel per clock, no stalls or backpressure.
module vga_cursor_pipe
    import vga_cursor_pipe_pkg::*;
#(
    parameter int               CNT_W   = VGA_CNT_W,
    parameter int               RGB_W   = 12,
    parameter int               LAT     = 3,
    parameter int               CUR_W   = 16,
    parameter int               CUR_H   = 16,
    parameter logic [RGB_W-1:0] CUR_RGB = 12'hFFF
) (
    input  logic              pclk,
    input  logic              rst,
    vga_cursor_pipe_if.slave  pix
);
    localparam int DW = CNT_W + 1;
    localparam int XD = LAT - 3;

    localparam logic signed [DW-1:0] CW_LIM  = DW'(CUR_W);
    localparam logic signed [DW-1:0] CW_LAST = DW'(CUR_W - 1);
    localparam logic signed [DW-1:0] CH_LIM  = DW'(CUR_H);
    localparam logic signed [DW-1:0] CH_LAST = DW'(CUR_H - 1);

    typedef struct packed {
        logic             vs;
        logic             hs;
        logic             blank;
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic [RGB_W-1:0] rgb;
    } tim_t;

    localparam int BW = $bits(tim_t) + 4;

    // Frame-synchronous shadow of the cursor controls
    logic             vs_prev_q;
    logic [CNT_W-1:0] xpos_sh_q, ypos_sh_q;
    logic [1:0]       mode_sh_q;
    logic             vs_rise;

    assign vs_rise = pix.vs_in & ~vs_prev_q;

    always_ff @(posedge pclk) begin
        if (rst) begin
            vs_prev_q <= 1'b0;
            xpos_sh_q <= '0;
            ypos_sh_q <= '0;
            mode_sh_q <= MODE_OFF;
        end else begin
            vs_prev_q <= pix.vs_in;
            if (vs_rise) begin
                xpos_sh_q <= pix.xpos;
                ypos_sh_q <= pix.ypos;
                mode_sh_q <= pix.mode;
            end
        end
    end

    // Stage 1: register inputs, one-bit-wider offsets so no wrap past the counter limit
    tim_t                  s1_q;
    logic signed [DW-1:0]  dx_d, dy_d, dx_q, dy_q;
    logic [1:0]            s1_mode_q;

    assign dx_d = $signed({1'b0, pix.hcount_in} - {1'b0, xpos_sh_q});
    assign dy_d = $signed({1'b0, pix.vcount_in} - {1'b0, ypos_sh_q});

    always_ff @(posedge pclk) begin
        if (rst) begin
            s1_q      <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            s1_mode_q <= MODE_OFF;
        end else begin
            s1_q      <= {pix.vs_in, pix.hs_in, pix.blank_in,
                          pix.hcount_in, pix.vcount_in, pix.rgb_in};
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            s1_mode_q <= mode_sh_q;
        end
    end

    // Stage 2: cursor hit test
    tim_t       s2_q;
    logic       inside_d, border_d, inside_q, border_q;
    logic [1:0] s2_mode_q;

    assign inside_d = !dx_q[DW-1] && (dx_q < CW_LIM) && !dy_q[DW-1] && (dy_q < CH_LIM);
    assign border_d = inside_d && ((dx_q == '0) || (dx_q == CW_LAST) ||
                                   (dy_q == '0) || (dy_q == CH_LAST));

    always_ff @(posedge pclk) begin
        if (rst) begin
            s2_q      <= '0;
            inside_q  <= 1'b0;
            border_q  <= 1'b0;
            s2_mode_q <= MODE_OFF;
        end else begin
            s2_q      <= s1_q;
            inside_q  <= inside_d;
            border_q  <= border_d;
            s2_mode_q <= s1_mode_q;
        end
    end

    // Extra latency applied to the whole bundle keeps timing and RGB co-aligned
    logic [BW-1:0] dl_in, dl_out;
    tim_t          d_tim;
    logic          d_inside, d_border;
    logic [1:0]    d_mode;

    assign dl_in = {s2_q, inside_q, border_q, s2_mode_q};

    delay_line #(.WIDTH(BW), .DEPTH(XD)) u_delay (
        .clk (pclk),
        .rst (rst),
        .d_i (dl_in),
        .q_o (dl_out)
    );

    assign {d_tim, d_inside, d_border, d_mode} = dl_out;

    // Stage 3: composite and register outputs
    tim_t             out_q;
    logic [RGB_W-1:0] rgb_d;

    always_comb begin
        rgb_d = d_tim.rgb;
        if (d_tim.blank)                                rgb_d = '0;
        else if (d_mode == MODE_SOLID   && d_inside)    rgb_d = CUR_RGB;
        else if (d_mode == MODE_OUTLINE && d_border)    rgb_d = CUR_RGB;
        else if (d_mode == MODE_INVERT  && d_inside)    rgb_d = ~d_tim.rgb;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q     <= d_tim;
            out_q.rgb <= rgb_d;
        end
    end

    assign pix.vs_out     = out_q.vs;
    assign pix.hs_out     = out_q.hs;
    assign pix.blank_out  = out_q.blank;
    assign pix.hcount_out = out_q.hcount;
    assign pix.vcount_out = out_q.vcount;
    assign pix.rgb_out    = out_q.rgb;
endmodule
